xmem_bus_ctrl: RTL and testbench

- Clocked front end between the AVR external-memory bus (multiplexed ad, high address a, ale, nRD, nWR) and the FPGA peripheral register file (motors, encoders, servos, digital in).
- Synchronises the bus strobes into the clk domain and latches the address.
- Issues single-cycle register read/write strobes.
- Sequences atomic 16-bit accesses (snapshot on low-byte read, staged commit on high-byte write) so multi-byte encoder/servo values never tear.

---
 rtl/xmem_bus_ctrl_if.sv | 34 +++
 rtl/xmem_bus_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_xmem_bus_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/xmem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : xmem_bus_ctrl_if
// Brief    : AVR external-memory bus pins plus peripheral register-file port.
// Revision : 1.0 - initial release
// ============================================================================
interface xmem_bus_ctrl_if;
    logic [7:0]  ad_in;
    logic [7:0]  a;
    logic        ale;
    logic        nRD;
    logic        nWR;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  reg_addr;
    logic        reg_rd;
    logic [7:0]  reg_rdata;
    logic [7:0]  reg_rdata_hi;
    logic        reg_wr;
    logic        reg_wr16;
    logic [15:0] reg_wdata;
    logic        bus_err;

    modport slave (
        input  ad_in, a, ale, nRD, nWR, reg_rdata, reg_rdata_hi,
        output ad_out, ad_oe, reg_addr, reg_rd, reg_wr, reg_wr16, reg_wdata, bus_err
    );

    modport master (
        output ad_in, a, ale, nRD, nWR, reg_rdata, reg_rdata_hi,
        input  ad_out, ad_oe, reg_addr, reg_rd, reg_wr, reg_wr16, reg_wdata, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/xmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xmem_bus_ctrl
// Brief    : AVR XMEM bus front end with atomic 16-bit read/write sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module xmem_bus_ctrl #(
    parameter logic [7:0] BASE_HI     = 8'h11,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] WIDE_RD_LO  = 8'h0C,
    parameter logic [7:0] WIDE_RD_HI  = 8'h13,
    parameter logic [7:0] WIDE_WR_LO  = 8'h20,
    parameter logic [7:0] WIDE_WR_HI  = 8'h2B
) (
    input  wire logic         clk,
    input  wire logic         rst,
    xmem_bus_ctrl_if.slave    bus
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_REQ  = 3'd1;
    localparam logic [2:0] c_RD_CAP  = 3'd2;
    localparam logic [2:0] c_RD_HOLD = 3'd3;
    localparam logic [2:0] c_WR_ACT  = 3'd4;
    localparam logic [2:0] c_ERR     = 3'd5;

    logic [SYNC_STAGES-1:0][7:0] r_ad_sync;
    logic [SYNC_STAGES-1:0][7:0] r_a_sync;
    logic [SYNC_STAGES-1:0][2:0] r_ctl_sync;   // {ale, nRD, nWR}
    logic        r_nrd_prev, r_nwr_prev;
    logic [7:0]  r_addr_lo, r_addr_hi;
    logic [2:0]  r_state, w_state_nxt;
    logic [7:0]  r_ad_out, r_shadow, r_stage, r_wbuf;
    logic        r_ad_oe, r_reg_wr, r_reg_wr16, r_bus_err;
    logic [15:0] r_reg_wdata;

    logic [7:0]  w_s_ad, w_s_a;
    logic        w_s_ale, w_s_nrd, w_s_nwr;
    logic        w_rd_fall, w_wr_fall, w_hit, w_rd_wide, w_wr_wide;
    logic        w_rd_req, w_cap, w_oe_clr, w_wbuf_ld, w_wr_done, w_err;

    assign w_s_ad    = r_ad_sync[SYNC_STAGES-1];
    assign w_s_a     = r_a_sync[SYNC_STAGES-1];
    assign w_s_ale   = r_ctl_sync[SYNC_STAGES-1][2];
    assign w_s_nrd   = r_ctl_sync[SYNC_STAGES-1][1];
    assign w_s_nwr   = r_ctl_sync[SYNC_STAGES-1][0];
    assign w_rd_fall = r_nrd_prev & ~w_s_nrd;
    assign w_wr_fall = r_nwr_prev & ~w_s_nwr;
    assign w_hit     = (r_addr_hi == BASE_HI);
    assign w_rd_wide = (r_addr_lo >= WIDE_RD_LO) && (r_addr_lo <= WIDE_RD_HI);
    assign w_wr_wide = (r_addr_lo >= WIDE_WR_LO) && (r_addr_lo <= WIDE_WR_HI);

    // Strobes idle high and ale idles low so reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ad_sync  <= '0;
            r_a_sync   <= '0;
            r_ctl_sync <= {SYNC_STAGES{3'b011}};
            r_nrd_prev <= 1'b1;
            r_nwr_prev <= 1'b1;
        end else begin
            r_ad_sync  <= {r_ad_sync[SYNC_STAGES-2:0], bus.ad_in};
            r_a_sync   <= {r_a_sync[SYNC_STAGES-2:0], bus.a};
            r_ctl_sync <= {r_ctl_sync[SYNC_STAGES-2:0], {bus.ale, bus.nRD, bus.nWR}};
            r_nrd_prev <= w_s_nrd;
            r_nwr_prev <= w_s_nwr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_req    = 1'b0;
        w_cap       = 1'b0;
        w_oe_clr    = 1'b0;
        w_wbuf_ld   = 1'b0;
        w_wr_done   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_rd_fall || w_wr_fall) begin
                    if (!w_s_nrd && !w_s_nwr) begin
                        w_err       = 1'b1;
                        w_state_nxt = c_ERR;
                    end else if (w_rd_fall) begin
                        w_state_nxt = c_RD_REQ;
                    end else begin
                        w_state_nxt = c_WR_ACT;
                    end
                end
            end
            c_RD_REQ: begin
                w_rd_req    = w_hit;
                w_state_nxt = c_RD_CAP;
            end
            c_RD_CAP: begin
                w_cap       = 1'b1;
                w_state_nxt = c_RD_HOLD;
            end
            c_RD_HOLD: begin
                if (w_s_nrd) begin
                    w_oe_clr    = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            c_WR_ACT: begin
                if (!w_s_nwr) begin
                    w_wbuf_ld = 1'b1;
                end else begin
                    w_wr_done   = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            c_ERR: begin
                if (w_s_nrd && w_s_nwr) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_lo   <= '0;
            r_addr_hi   <= '0;
            r_ad_out    <= '0;
            r_ad_oe     <= 1'b0;
            r_shadow    <= '0;
            r_stage     <= '0;
            r_wbuf      <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_wr16  <= 1'b0;
            r_reg_wdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_reg_wr   <= 1'b0;
            r_reg_wr16 <= 1'b0;
            r_bus_err  <= w_err;
            if (w_s_ale) begin
                r_addr_lo <= w_s_ad;
                r_addr_hi <= w_s_a;
            end
            // Odd half of a wide read returns the high byte frozen by the even half.
            if (w_cap) begin
                r_ad_oe <= w_hit;
                if (w_hit) begin
                    if (w_rd_wide && r_addr_lo[0]) begin
                        r_ad_out <= r_shadow;
                    end else begin
                        r_ad_out <= bus.reg_rdata;
                    end
                    if (w_rd_wide && !r_addr_lo[0]) r_shadow <= bus.reg_rdata_hi;
                end
            end
            if (w_oe_clr)  r_ad_oe <= 1'b0;
            if (w_wbuf_ld) r_wbuf  <= w_s_ad;
            if (w_wr_done && w_hit) begin
                if (w_wr_wide && !r_addr_lo[0]) begin
                    r_stage <= r_wbuf;
                end else if (w_wr_wide) begin
                    r_reg_wdata <= {r_wbuf, r_stage};
                    r_reg_wr16  <= 1'b1;
                end else begin
                    r_reg_wdata[7:0] <= r_wbuf;
                    r_reg_wr         <= 1'b1;
                end
            end
        end
    end

    assign bus.ad_out    = r_ad_out;
    assign bus.ad_oe     = r_ad_oe;
    assign bus.reg_addr  = r_addr_lo;
    assign bus.reg_rd    = w_rd_req;
    assign bus.reg_wr    = r_reg_wr;
    assign bus.reg_wr16  = r_reg_wr16;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_xmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_xmem_bus_ctrl
// Brief    : Scoreboard bench for the XMEM bus front end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xmem_bus_ctrl;

    localparam int c_SYNC = 2;
    localparam int c_K_WR = 1, c_K_WR16 = 2, c_K_RD = 3, c_K_ERR = 4;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rd_value16;
    logic        oe_q = 1'b0;
    ev_t         sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    xmem_bus_ctrl_if bus ();

    xmem_bus_ctrl #(
        .BASE_HI     (8'h11),
        .SYNC_STAGES (c_SYNC),
        .WIDE_RD_LO  (8'h0C),
        .WIDE_RD_HI  (8'h13),
        .WIDE_WR_LO  (8'h20),
        .WIDE_WR_HI  (8'h2B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] addr, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic match_ev(input int kind, input logic [7:0] addr, input logic [15:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected_kind", kind, 0);
        end else begin
            e = sb.pop_front();
            check("sb_kind", kind, e.kind);
            check("sb_addr", addr, e.addr);
            check("sb_data", data, e.data);
        end
    endtask

    // Register-file model: data appears the cycle after reg_rd.
    always @(posedge clk) begin
        if (rst) begin
            bus.reg_rdata    <= 8'h00;
            bus.reg_rdata_hi <= 8'h00;
        end else if (bus.reg_rd) begin
            bus.reg_rdata    <= rd_value16[7:0];
            bus.reg_rdata_hi <= rd_value16[15:8];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.reg_wr)             match_ev(c_K_WR, bus.reg_addr, {8'h00, bus.reg_wdata[7:0]});
            if (bus.reg_wr16)           match_ev(c_K_WR16, bus.reg_addr, bus.reg_wdata);
            if (bus.ad_oe && !oe_q)     match_ev(c_K_RD, bus.reg_addr, {8'h00, bus.ad_out});
            if (bus.bus_err)            match_ev(c_K_ERR, 8'h00, 16'h0000);
        end
        oe_q = bus.ad_oe;
    end

    task automatic bus_latch(input logic [15:0] addr);
        @(posedge clk); #1;
        bus.a      = addr[15:8];
        bus.ad_in  = addr[7:0];
        bus.ale    = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.ale = 1'b0;
        repeat (c_SYNC + 2) @(posedge clk);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                             input logic exp_wr, input logic exp_wr16);
        bus_latch(addr);
        #1;
        bus.ad_in = data;
        bus.nWR   = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.nWR = 1'b1;
        repeat (c_SYNC) @(posedge clk);
        #1 check("wr_early", {30'd0, bus.reg_wr, bus.reg_wr16}, 32'd0);
        @(posedge clk);
        #1 check("wr_strobe", {30'd0, bus.reg_wr, bus.reg_wr16}, {30'd0, exp_wr, exp_wr16});
        repeat (3) @(posedge clk);
    endtask

    task automatic bus_read_start(input logic [15:0] addr, input logic hit, input logic [7:0] exp_data);
        if (hit) push_ev(c_K_RD, addr[7:0], {8'h00, exp_data});
        bus_latch(addr);
        #1 bus.nRD = 1'b0;
        repeat (c_SYNC) @(posedge clk);
        #1 check("rd_early", {31'd0, bus.reg_rd}, 32'd0);
        @(posedge clk);
        #1 check("rd_req", {31'd0, bus.reg_rd}, {31'd0, hit});
        @(posedge clk);
        #1 check("oe_early", {31'd0, bus.ad_oe}, 32'd0);
        @(posedge clk);
        #1 check("oe_lat", {31'd0, bus.ad_oe}, {31'd0, hit});
        repeat (3) @(posedge clk);
    endtask

    task automatic bus_read_end(input logic hit);
        #1 bus.nRD = 1'b1;
        repeat (c_SYNC) @(posedge clk);
        #1 check("oe_hold", {31'd0, bus.ad_oe}, {31'd0, hit});
        @(posedge clk);
        #1 check("oe_release", {31'd0, bus.ad_oe}, 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        bus.ad_in  = 8'h00;
        bus.a      = 8'h00;
        bus.ale    = 1'b0;
        bus.nRD    = 1'b1;
        bus.nWR    = 1'b1;
        rd_value16 = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ad_oe",    {31'd0, bus.ad_oe},    32'd0);
        check("rst_ad_out",   {24'd0, bus.ad_out},   32'd0);
        check("rst_reg_rd",   {31'd0, bus.reg_rd},   32'd0);
        check("rst_reg_wr",   {31'd0, bus.reg_wr},   32'd0);
        check("rst_reg_wr16", {31'd0, bus.reg_wr16}, 32'd0);
        check("rst_bus_err",  {31'd0, bus.bus_err},  32'd0);
        check("rst_wdata",    {16'd0, bus.reg_wdata}, 32'd0);
        check("rst_addr",     {24'd0, bus.reg_addr}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Byte write
        push_ev(c_K_WR, 8'h01, 16'h005A);
        bus_write(16'h1101, 8'h5A, 1'b1, 1'b0);

        // Byte read
        rd_value16 = 16'h00A5;
        bus_read_start(16'h111E, 1'b1, 8'hA5);
        bus_read_end(1'b1);

        // Atomic encoder read: odd half must return the snapshot, not live data
        rd_value16 = 16'h1234;
        bus_read_start(16'h110C, 1'b1, 8'h34);
        bus_read_end(1'b1);
        rd_value16 = 16'h5678;
        bus_read_start(16'h110D, 1'b1, 8'h12);
        bus_read_end(1'b1);

        // Servo commit
        bus_write(16'h1120, 8'hFF, 1'b0, 1'b0);
        push_ev(c_K_WR16, 8'h21, 16'h03FF);
        bus_write(16'h1121, 8'h03, 1'b0, 1'b1);

        // Misses
        bus_read_start(16'h2000, 1'b0, 8'h00);
        bus_read_end(1'b0);
        bus_write(16'h3001, 8'h77, 1'b0, 1'b0);

        // Simultaneous strobes
        bus_latch(16'h1105);
        push_ev(c_K_ERR, 8'h00, 16'h0000);
        #1;
        bus.nRD = 1'b0;
        bus.nWR = 1'b0;
        repeat (c_SYNC) @(posedge clk);
        #1 check("err_early", {31'd0, bus.bus_err}, 32'd0);
        @(posedge clk);
        #1 check("err_pulse", {31'd0, bus.bus_err}, 32'd1);
        @(posedge clk);
        #1 check("err_once", {31'd0, bus.bus_err}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        bus.nRD = 1'b1;
        bus.nWR = 1'b1;
        repeat (c_SYNC + 4) @(posedge clk);

        // Reset while holding read data on the bus
        rd_value16 = 16'h00C3;
        bus_read_start(16'h1130, 1'b1, 8'hC3);
        #1;
        rst     = 1'b1;
        bus.nRD = 1'b1;
        @(posedge clk);
        #1 check("rst_mid_read_oe", {31'd0, bus.ad_oe}, 32'd0);
        rst = 1'b0;
        repeat (c_SYNC + 2) @(posedge clk);
        push_ev(c_K_WR, 8'h02, 16'h003C);
        bus_write(16'h1102, 8'h3C, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
